mcp_spi_master: RTL and testbench

//  SPI source (mode 0: CPOL=0, CPHA=0) driving MCP23S17-style 3-byte transactions: opcode+R/W, register addr, one data byte.

---
 rtl/mcp_spi_master.sv | 186 ++++++++++++++++++
 tb/tb_mcp_spi_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcp_spi_master.sv
// Mode-0 SPI master issuing one MCP23S17-style 3-byte register access
// (opcode+R/W, address, data) per start_i request.
module mcp_spi_master #(
    parameter int         CLK_DIV  = 4,
    parameter logic [2:0] DEV_ADDR = 3'b000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int CW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        rw_q, rw_d;
    logic        sclk_q, sclk_d;
    logic        csn_q, csn_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;

    logic [23:0] frame_s;
    logic        cnt_end_s;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 5'd0;
            tx_q    <= 24'd0;
            rx_q    <= 8'd0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: every phase lasts exactly CLK_DIV clk cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rw_d      = rw_q;
        sclk_d    = sclk_q;
        csn_d     = csn_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        frame_s   = {4'b0100, DEV_ADDR, rw_i, addr_i, wdata_i};
        cnt_end_s = (cnt_q == CW'(CLK_DIV - 1));

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rw_d    = rw_i;
                    tx_d    = frame_s;
                    mosi_d  = frame_s[23];
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = 5'd0;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_end_s) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + 5'd1;
                    rx_d    = {rx_q[6:0], miso_i};
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_end_s) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == 5'd24) begin
                            state_d = S_HOLD;
                        end else begin
                            tx_d   = {tx_q[22:0], 1'b0};
                            mosi_d = tx_q[22];
                        end
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 5'd1;
                        rx_d   = {rx_q[6:0], miso_i};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_end_s) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                    // rx_q now holds samples 17..24, i.e. the data byte
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_end_s) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                sclk_d  = 1'b0;
                csn_d   = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign sclk_o  = sclk_q;
    assign csn_o   = csn_q;
    assign mosi_o  = mosi_q;

endmodule

// File: tb/tb_mcp_spi_master.sv
// Bench for mcp_spi_master: two instances (CLK_DIV=4/DEV 0, CLK_DIV=2/DEV 5)
// exercised by a vector table, random transactions and reset/ignore sequences.
module tb_mcp_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       start_s [2];
    logic       rw_s    [2];
    logic       miso_s  [2];
    logic [7:0] addr_s  [2];
    logic [7:0] wdata_s [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       sclk_s  [2];
    logic       csn_s   [2];
    logic       mosi_s  [2];
    logic [7:0] rdata_s [2];

    mcp_spi_master #(.CLK_DIV(4), .DEV_ADDR(3'b000)) u_a (
        .clk(clk), .rstn(rstn), .start_i(start_s[0]), .rw_i(rw_s[0]),
        .addr_i(addr_s[0]), .wdata_i(wdata_s[0]), .busy_o(busy_s[0]),
        .done_o(done_s[0]), .rdata_o(rdata_s[0]), .sclk_o(sclk_s[0]),
        .csn_o(csn_s[0]), .mosi_o(mosi_s[0]), .miso_i(miso_s[0])
    );

    mcp_spi_master #(.CLK_DIV(2), .DEV_ADDR(3'b101)) u_b (
        .clk(clk), .rstn(rstn), .start_i(start_s[1]), .rw_i(rw_s[1]),
        .addr_i(addr_s[1]), .wdata_i(wdata_s[1]), .busy_o(busy_s[1]),
        .done_o(done_s[1]), .rdata_o(rdata_s[1]), .sclk_o(sclk_s[1]),
        .csn_o(csn_s[1]), .mosi_o(mosi_s[1]), .miso_i(miso_s[1])
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] model_rdata [2];

    typedef struct {
        int         w;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] resp;
        logic [7:0] exp_op;
        logic [7:0] exp_rdata;
    } vec_t;

    function automatic int div_of(input int w);
        return (w == 0) ? 4 : 2;
    endfunction

    function automatic logic [2:0] dev_of(input int w);
        return (w == 0) ? 3'b000 : 3'b101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full frame on DUT w with a sink model on miso; pa/pb are extra start pulses.
    task automatic run_txn(input int w, input logic rw, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] resp,
                           input logic [23:0] exp_frame, input logic [7:0] exp_rdata,
                           input int pa, input int pb);
        int d = div_of(w);
        int rises = 0, falls = 0, first_rise = -1, done_k = -1, busy_low_k = -1;
        int done_cnt = 0, tog_err = 0, quiet_err = 0;
        logic [23:0] cap = 24'd0;
        logic [23:0] resp_word;
        logic prev_sclk = 1'b0;
        logic csn_at_done = 1'b0;
        logic [7:0] rd_at_done = 8'd0;
        resp_word = {16'($urandom), resp};
        @(negedge clk);
        start_s[w] = 1'b1; rw_s[w] = rw; addr_s[w] = addr; wdata_s[w] = wdata;
        @(posedge clk);
        for (int k = 1; k <= 60 * d + 10; k++) begin
            @(negedge clk);
            start_s[w] = (k == pa) || (k == pb);
            rw_s[w]    = 1'($urandom);
            addr_s[w]  = 8'($urandom);
            wdata_s[w] = 8'($urandom);
            if (sclk_s[w] && !prev_sclk) begin
                rises++;
                if (first_rise < 0) first_rise = k;
                cap = {cap[22:0], mosi_s[w]};
            end
            if (!sclk_s[w] && prev_sclk) falls++;
            if (csn_s[w] && (sclk_s[w] !== prev_sclk)) tog_err++;
            if (done_s[w]) begin
                done_cnt++;
                done_k      = k;
                csn_at_done = csn_s[w];
                rd_at_done  = rdata_s[w];
            end
            miso_s[w] = (!csn_s[w] && falls < 24) ? resp_word[23 - falls] : 1'b0;
            prev_sclk = sclk_s[w];
            if (!busy_s[w]) begin
                busy_low_k = k;
                break;
            end
        end
        start_s[w] = 1'b0;
        miso_s[w]  = 1'b0;
        for (int k = 0; k < 3 * d; k++) begin
            @(negedge clk);
            if (!csn_s[w] || busy_s[w] || sclk_s[w]) quiet_err++;
            if (done_s[w]) done_cnt++;
        end
        check("first_rise",  first_rise, 1 + d);
        check("rises",       rises, 24);
        check("falls",       falls, 24);
        check("mosi_frame",  cap, exp_frame);
        check("done_count",  done_cnt, 1);
        check("done_time",   done_k, 1 + 49 * d);
        check("busy_low",    busy_low_k, 1 + 50 * d);
        check("csn_at_done", csn_at_done, 1'b1);
        check("sclk_idle",   tog_err, 0);
        check("rdata_done",  rd_at_done, exp_rdata);
        check("rdata_after", rdata_s[w], exp_rdata);
        check("quiet_after", quiet_err, 0);
    endtask

    vec_t vecs [6];
    int   rand_dones;

    initial begin
        rstn = 1'b0;
        for (int w = 0; w < 2; w++) begin
            start_s[w] = 1'b0; rw_s[w] = 1'b0; miso_s[w] = 1'b0;
            addr_s[w] = 8'd0; wdata_s[w] = 8'd0; model_rdata[w] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            check("rst_csn",   csn_s[w], 1'b1);
            check("rst_sclk",  sclk_s[w], 1'b0);
            check("rst_mosi",  mosi_s[w], 1'b0);
            check("rst_busy",  busy_s[w], 1'b0);
            check("rst_done",  done_s[w], 1'b0);
            check("rst_rdata", rdata_s[w], 8'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        vecs[0] = '{0, 1'b0, 8'h0A, 8'h55, 8'h00, 8'h40, 8'h00};
        vecs[1] = '{0, 1'b1, 8'h12, 8'h00, 8'hF0, 8'h41, 8'hF0};
        vecs[2] = '{0, 1'b0, 8'h33, 8'hA5, 8'h77, 8'h40, 8'hF0};
        vecs[3] = '{1, 1'b1, 8'h07, 8'h00, 8'h3C, 8'h4B, 8'h3C};
        vecs[4] = '{1, 1'b0, 8'h08, 8'h99, 8'hC3, 8'h4A, 8'h3C};
        vecs[5] = '{0, 1'b1, 8'hFF, 8'h12, 8'h81, 8'h41, 8'h81};
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].w, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].resp,
                    {vecs[i].exp_op, vecs[i].addr, vecs[i].wdata}, vecs[i].exp_rdata, -1, -1);
            model_rdata[vecs[i].w] = vecs[i].exp_rdata;
        end

        // Start pulses mid-frame and during the deselect gap must be ignored
        for (int w = 0; w < 2; w++) begin
            run_txn(w, 1'b1, 8'h5A, 8'h00, 8'h6E,
                    24'(32'h4 << 20) | 24'(32'(dev_of(w)) << 17) | 24'(32'h1 << 16) | 24'(32'h5A << 8),
                    8'h6E, 20 * div_of(w), 49 * div_of(w) + 2);
            model_rdata[w] = 8'h6E;
        end

        for (int i = 0; i < 8; i++) begin
            int w = int'($urandom_range(1, 0));
            logic rw = 1'($urandom);
            logic [7:0] a = 8'($urandom);
            logic [7:0] wd = 8'($urandom);
            logic [7:0] rs = 8'($urandom);
            logic [23:0] fr;
            logic [7:0] er;
            fr = 24'(32'h4 << 20) | 24'(32'(dev_of(w)) << 17) | 24'(32'(rw) << 16)
               | 24'(32'(a) << 8) | 24'(wd);
            er = rw ? rs : model_rdata[w];
            run_txn(w, rw, a, wd, rs, fr, er, -1, -1);
            model_rdata[w] = er;
        end

        // Reset asserted after 10 sclk rises abandons the frame
        begin
            int rises = 0;
            logic prev = 1'b0;
            rand_dones = 0;
            @(negedge clk);
            start_s[0] = 1'b1; rw_s[0] = 1'b1; addr_s[0] = 8'h21;
            @(posedge clk);
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                start_s[0] = 1'b0;
                if (sclk_s[0] && !prev) rises++;
                prev = sclk_s[0];
                if (done_s[0]) rand_dones++;
                if (rises == 10) break;
            end
            check("rst_mid_rises", rises, 10);
            repeat (2) @(negedge clk);
            rstn = 1'b0;
            #1;
            check("rst_mid_csn",   csn_s[0], 1'b1);
            check("rst_mid_sclk",  sclk_s[0], 1'b0);
            check("rst_mid_busy",  busy_s[0], 1'b0);
            check("rst_mid_mosi",  mosi_s[0], 1'b0);
            check("rst_mid_rdata", rdata_s[0], 8'd0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (done_s[0]) rand_dones++;
            end
            check("rst_mid_nodone", rand_dones, 0);
            rstn = 1'b1;
            model_rdata[0] = 8'd0;
            model_rdata[1] = 8'd0;
        end
        run_txn(0, 1'b0, 8'h0A, 8'h55, 8'h00, 24'h400A55, 8'h00, -1, -1);
        run_txn(0, 1'b1, 8'h13, 8'h00, 8'hA7, 24'h411300, 8'hA7, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
